alu_wb_demux: RTL and testbench
===============================

ALU_WB_DEMUX -- requirements
Module: alu_wb_demux

Interface
REQ-001 Parameter WIDTH, default 16, data path width.
REQ-002 Parameter NDEST, default 5, number of write-back destinations.
REQ-003 Parameter DEPTH, default 2, result buffer entries.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 in_valid  input  1  ALU result available.
REQ-007 in_ready  output  1  block can accept a result this cycle.
REQ-008 sel  input  3  destination code: 0..4 = dest 0..4; 5..7 illegal.
REQ-009 data_in  input  WIDTH  ALU result.
REQ-010 flush  input  1  synchronous discard of all buffered results.
REQ-011 dst_ready  input  NDEST  per-destination accept; bit i high = dest i can be written.
REQ-012 wr_en  output  NDEST  one-hot write strobe, one cycle per result.
REQ-013 data_out  output  WIDTH  result driven with wr_en.
REQ-014 illegal_sel  output  1  one-cycle pulse when an accepted result carried sel 5..7.
REQ-015 wb_count  output  8  saturating count of completed write-backs.

Function
REQ-016 Accept occurs on an edge where in_valid and in_ready are both high; {sel, data_in} is pushed into the buffer.
REQ-017 in_ready SHALL be high exactly when occupancy < DEPTH; it SHALL NOT depend on a same-cycle pop (full buffer blocks input even while draining).
REQ-018 Accepted sel 5..7 SHALL be stored as dest 0 and pulse illegal_sel high for the cycle after the accept edge.
REQ-019 The head entry issues on an edge where occupancy > 0 and dst_ready[head dest] is high; it is popped at that edge.
REQ-020 On issue, wr_en SHALL be registered one-hot at the head dest and data_out at the head data, held exactly one cycle; otherwise wr_en = 0 and data_out holds its last value.
REQ-021 Minimum latency: result accepted at edge k issues at edge k+1 (wr_en high from k+1 to k+2) if its dest is ready.
REQ-022 Order SHALL be strictly FIFO; a stalled head (dest not ready) blocks all later entries.
REQ-023 Push and pop on the same edge SHALL leave occupancy unchanged and preserve order.
REQ-024 Occupancy states EMPTY, PARTIAL, FULL; transitions only by push/pop/flush; buffer pointers wrap modulo DEPTH.
REQ-025 flush SHALL have priority over push and pop: occupancy -> 0, no wr_en on that edge, the in_valid at that edge is dropped.
REQ-026 wb_count SHALL increment on every issue edge and saturate at 255.
REQ-027 dst_ready bits for non-head destinations SHALL have no effect.

Reset
REQ-028 rst SHALL immediately clear occupancy, pointers, wr_en, data_out, illegal_sel and wb_count to 0; in_ready = 1 one clk edge after rst deasserts.
REQ-029 rst asserted mid-transfer SHALL discard buffered results without any further wr_en pulse.

Structure
REQ-030 WIDTH, NDEST, DEPTH defaults and destination codes (0..4, illegal range 5..7) SHALL live in the shared core package used by the ALU operand mux.
REQ-031 The buffer SHALL be one sub-module, wb_fifo (push, pop, flush, full, empty, head), instantiated once.

Verification
REQ-032 Reset: rst=1 mid-stream with 2 buffered -> wr_en=0, wb_count=0, in_ready=1 after release, no write occurs.
REQ-033 Single write: sel=3, data_in=16'h0008, dst_ready=5'b11111 -> wr_en=5'b01000, data_out=16'h0008 one cycle after accept, wb_count=1.
REQ-034 Backpressure: dst_ready[1]=0, push sel=1 (16'h0001) then sel=2 (16'h0004) -> in_ready=0 after two accepts, no wr_en; raise dst_ready[1] -> wr_en 5'b00010 then 5'b00100 on consecutive cycles, in order.
REQ-035 Illegal code: sel=6, data_in=16'hFFFF -> illegal_sel pulse 1 cycle, wr_en=5'b00001, data_out=16'hFFFF.
REQ-036 Flush with simultaneous in_valid while full -> no wr_en, occupancy 0, flushed and same-cycle data never appear.
REQ-037 Streaming 300 results, all dests ready -> one wr_en per cycle after first, wb_count saturates at 255.

Source files
------------

// File: rtl/alu_wb_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_demux_pkg
// Description : Shared core parameters, destination codes and helpers for the
//               ALU write-back path and operand mux.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_wb_demux_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_NDEST = 5;
    localparam int unsigned DEF_DEPTH = 2;
    localparam int unsigned SEL_W     = 3;

    typedef enum logic [SEL_W-1:0] {
        SEL_D0   = 3'd0,
        SEL_D1   = 3'd1,
        SEL_D2   = 3'd2,
        SEL_D3   = 3'd3,
        SEL_D4   = 3'd4,
        SEL_ILL5 = 3'd5,
        SEL_ILL6 = 3'd6,
        SEL_ILL7 = 3'd7
    } wb_sel_e;

    localparam logic [SEL_W-1:0] SEL_LAST_LEGAL = SEL_D4;

    function automatic logic sel_is_illegal(input logic [SEL_W-1:0] s);
        return s > SEL_LAST_LEGAL;
    endfunction

    // Illegal codes are steered to destination 0.
    function automatic logic [SEL_W-1:0] sel_to_dest(input logic [SEL_W-1:0] s);
        return sel_is_illegal(s) ? SEL_D0 : s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_wb_demux_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_fifo
// Description : Small result buffer with flush; occupancy tracked as an
//               EMPTY/PARTIAL/FULL state machine plus an entry count.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_fifo #(
    parameter int unsigned WIDTH = 19,
    parameter int unsigned DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic             i_flush,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    localparam logic [1:0] S_EMPTY   = 2'd0;
    localparam logic [1:0] S_PARTIAL = 2'd1;
    localparam logic [1:0] S_FULL    = 2'd2;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_count_nxt;
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign w_do_push = i_push & (r_state != S_FULL)  & ~i_flush;
    assign w_do_pop  = i_pop  & (r_state != S_EMPTY) & ~i_flush;

    always_comb begin
        w_count_nxt = r_count;
        if (i_flush) begin
            w_count_nxt = '0;
        end else if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + 1'b1;
        end else if (w_do_pop && !w_do_push) begin
            w_count_nxt = r_count - 1'b1;
        end

        w_state_nxt = S_PARTIAL;
        if (w_count_nxt == '0) begin
            w_state_nxt = S_EMPTY;
        end else if (w_count_nxt == CNT_W'(DEPTH)) begin
            w_state_nxt = S_FULL;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_EMPTY;
            r_count  <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            if (i_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
                if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            end
        end
    end

    // Storage needs no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_full  = (r_state == S_FULL);
    assign o_empty = (r_state == S_EMPTY);
    assign o_head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/alu_wb_demux.sv
`default_nettype none
// ============================================================================
// Module      : alu_wb_demux
// Description : Buffers ALU results and writes each, in order, to one of
//               NDEST destinations with a registered one-hot strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_wb_demux
    import alu_wb_demux_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned NDEST = DEF_NDEST,
    parameter int unsigned DEPTH = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] data_in,
    input  logic             flush,
    input  logic [NDEST-1:0] dst_ready,
    output logic [NDEST-1:0] wr_en,
    output logic [WIDTH-1:0] data_out,
    output logic             illegal_sel,
    output logic [7:0]       wb_count
);

    localparam int unsigned ENT_W = SEL_W + WIDTH;

    logic             w_full;
    logic             w_empty;
    logic [ENT_W-1:0] w_head;
    logic [SEL_W-1:0] w_head_dest;
    logic [WIDTH-1:0] w_head_data;
    logic [NDEST-1:0] w_dest_hit;
    logic             w_accept;
    logic             w_issue;

    logic [NDEST-1:0] r_wr_en;
    logic [WIDTH-1:0] r_data_out;
    logic             r_illegal;
    logic [7:0]       r_wb_count;

    // Readiness reflects occupancy only, so a full buffer stalls input even while draining.
    assign in_ready    = ~w_full;
    assign w_accept    = in_valid & ~w_full & ~flush;
    assign w_head_dest = w_head[ENT_W-1 -: SEL_W];
    assign w_head_data = w_head[WIDTH-1:0];

    for (genvar g = 0; g < NDEST; g++) begin : g_dest_hit
        assign w_dest_hit[g] = (w_head_dest == SEL_W'(g));
    end

    assign w_issue = ~w_empty & (|(w_dest_hit & dst_ready)) & ~flush;

    wb_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (DEPTH)
    ) u_wb_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_accept),
        .i_pop   (w_issue),
        .i_flush (flush),
        .i_data  ({sel_to_dest(sel), data_in}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_en    <= '0;
            r_data_out <= '0;
            r_illegal  <= 1'b0;
            r_wb_count <= '0;
        end else begin
            r_wr_en   <= w_issue ? w_dest_hit : '0;
            r_illegal <= w_accept & sel_is_illegal(sel);
            if (w_issue) begin
                r_data_out <= w_head_data;
                if (r_wb_count != 8'hFF) r_wb_count <= r_wb_count + 8'd1;
            end
        end
    end

    assign wr_en       = r_wr_en;
    assign data_out    = r_data_out;
    assign illegal_sel = r_illegal;
    assign wb_count    = r_wb_count;

endmodule
`default_nettype wire

// File: tb/tb_alu_wb_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_wb_demux
// Description : Scoreboard bench for alu_wb_demux with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_wb_demux;

    localparam int unsigned W     = 16;
    localparam int unsigned ND    = 5;
    localparam int unsigned DEPTH = 2;

    typedef struct {
        logic [2:0]   dest;
        logic [W-1:0] data;
    } ent_t;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [2:0]    sel;
    logic [W-1:0]  data_in;
    logic          flush;
    logic [ND-1:0] dst_ready;
    logic [ND-1:0] wr_en;
    logic [W-1:0]  data_out;
    logic          illegal_sel;
    logic [7:0]    wb_count;

    ent_t         mq[$];
    ent_t         sb[$];
    logic         exp_issue;
    int           m_cnt;
    logic         m_ill;
    logic [W-1:0] m_last;
    int           n_vec;
    int           n_err;

    alu_wb_demux #(.WIDTH(W), .NDEST(ND), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .sel         (sel),
        .data_in     (data_in),
        .flush       (flush),
        .dst_ready   (dst_ready),
        .wr_en       (wr_en),
        .data_out    (data_out),
        .illegal_sel (illegal_sel),
        .wb_count    (wb_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle, entered and left on a falling edge.
    task automatic step(input logic v, input logic [2:0] s, input logic [W-1:0] d,
                        input logic f, input logic [ND-1:0] r);
        logic acc;
        logic iss;
        ent_t e;
        chk("in_ready", in_ready, (mq.size() < DEPTH));
        chk("illegal_sel", illegal_sel, m_ill);
        chk("wb_count", wb_count, m_cnt);
        in_valid  = v;
        sel       = s;
        data_in   = d;
        flush     = f;
        dst_ready = r;
        acc = v && (mq.size() < DEPTH) && !f;
        iss = (mq.size() > 0) && r[mq[0].dest] && !f;
        exp_issue = iss;
        if (iss) begin
            sb.push_back(mq.pop_front());
            if (m_cnt < 255) m_cnt++;
        end
        if (acc) begin
            e.dest = (s > 3'd4) ? 3'd0 : s;
            e.data = d;
            mq.push_back(e);
        end
        m_ill = acc && (s > 3'd4);
        if (f) mq.delete();
        @(negedge clk);
    endtask

    task automatic idle(input int n, input logic [ND-1:0] r);
        for (int i = 0; i < n; i++) step(1'b0, 3'd0, '0, 1'b0, r);
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        mq.delete();
        sb.delete();
        exp_issue = 1'b0;
        m_cnt     = 0;
        m_ill     = 1'b0;
        m_last    = '0;
        #1;
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wb_count", wb_count, 0);
        chk("rst_illegal", illegal_sel, 0);
        chk("rst_data_out", data_out, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: pops the scoreboard whenever a write strobe appears.
    initial begin
        ent_t e;
        forever begin
            @(posedge clk);
            #1;
            if (!rst) begin
                chk("wr_active", (wr_en != 0), exp_issue);
                if (wr_en != 0) begin
                    if (sb.size() == 0) begin
                        chk("sb_unexpected_wr", wr_en, 0);
                    end else begin
                        e = sb.pop_front();
                        chk("wr_en", wr_en, 32'd1 << e.dest);
                        chk("data_out", data_out, e.data);
                        m_last = e.data;
                    end
                end else begin
                    chk("data_hold", data_out, m_last);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec     = 0;
        n_err     = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        sel       = '0;
        data_in   = '0;
        flush     = 1'b0;
        dst_ready = '0;
        do_reset();

        // Single write to dest 3.
        step(1'b1, 3'd3, 16'h0008, 1'b0, 5'b11111);
        idle(2, 5'b11111);

        // Backpressure on dest 1 stalls the following dest-2 entry.
        step(1'b1, 3'd1, 16'h0001, 1'b0, 5'b11101);
        step(1'b1, 3'd2, 16'h0004, 1'b0, 5'b11101);
        step(1'b1, 3'd4, 16'h1234, 1'b0, 5'b11101);
        idle(2, 5'b11101);
        idle(3, 5'b11111);

        // Illegal code steered to dest 0.
        step(1'b1, 3'd6, 16'hFFFF, 1'b0, 5'b11111);
        idle(2, 5'b11111);

        // Flush while full with a simultaneous offer.
        step(1'b1, 3'd2, 16'hAAAA, 1'b0, 5'b00000);
        step(1'b1, 3'd3, 16'hBBBB, 1'b0, 5'b00000);
        step(1'b1, 3'd4, 16'hCCCC, 1'b1, 5'b11111);
        idle(3, 5'b11111);

        // Reset with two results buffered.
        step(1'b1, 3'd0, 16'h5555, 1'b0, 5'b00000);
        step(1'b1, 3'd1, 16'h6666, 1'b0, 5'b00000);
        do_reset();
        idle(3, 5'b11111);

        // Streaming past the wb_count saturation point.
        for (int i = 0; i < 300; i++)
            step(1'b1, 3'($urandom_range(0, 4)), 16'($urandom), 1'b0, 5'b11111);
        idle(2, 5'b11111);
        chk("wb_count_sat", wb_count, 255);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            step(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 16'($urandom),
                 ($urandom_range(0, 31) == 0), 5'($urandom));

        idle(4, 5'b11111);
        chk("sb_drained", sb.size(), 0);
        chk("model_drained", mq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
